// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time-set controller for the digital clock.
// Optional macro SET_TIMEOUT_EN abandons an idle edit after TIMEOUT_TICKS.
module clock_set_ctrl #(
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic       Clk_1sec,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    output logic [4:0] init_hours,
    output logic [5:0] init_minutes,
    output logic [5:0] init_seconds,
    output logic       load,
    output logic       set_active,
    output logic [1:0] field_sel
);

    typedef enum logic [2:0] {
        S_RUN,
        S_SET_H,
        S_SET_M,
        S_SET_S,
        S_COMMIT
    } state_t;

    state_t     r_state;
    logic       r_mode_prev;
    logic       r_inc_prev;
    logic       r_dec_prev;
    logic [4:0] r_hours;
    logic [5:0] r_minutes;
    logic [5:0] r_seconds;
    logic       r_load;
    logic       r_set_active;
    logic [1:0] r_field_sel;

    logic       w_mode_rise;
    logic       w_inc_rise;
    logic       w_dec_rise;
    logic       w_edit_rise;
    logic       w_inc_only;
    logic       w_dec_only;
    logic       w_timeout;
    logic [4:0] w_hours_inc;
    logic [4:0] w_hours_dec;
    logic [5:0] w_minutes_inc;
    logic [5:0] w_minutes_dec;
    logic [5:0] w_seconds_inc;
    logic [5:0] w_seconds_dec;

    assign w_mode_rise = btn_mode & ~r_mode_prev;
    assign w_inc_rise  = btn_inc  & ~r_inc_prev;
    assign w_dec_rise  = btn_dec  & ~r_dec_prev;
    assign w_edit_rise = w_inc_rise | w_dec_rise;
    assign w_inc_only  = w_inc_rise & ~w_dec_rise;
    assign w_dec_only  = w_dec_rise & ~w_inc_rise;

    assign w_hours_inc   = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
    assign w_hours_dec   = (r_hours == 5'd0) ? 5'd23 : r_hours - 5'd1;
    assign w_minutes_inc = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
    assign w_minutes_dec = (r_minutes == 6'd0) ? 6'd59 : r_minutes - 6'd1;
    assign w_seconds_inc = (r_seconds == 6'd59) ? 6'd0 : r_seconds + 6'd1;
    assign w_seconds_dec = (r_seconds == 6'd0) ? 6'd59 : r_seconds - 6'd1;

    assign init_hours   = r_hours;
    assign init_minutes = r_minutes;
    assign init_seconds = r_seconds;
    assign load         = r_load;
    assign set_active   = r_set_active;
    assign field_sel    = r_field_sel;

`ifdef SET_TIMEOUT_EN
    logic [5:0] r_idle;

    assign w_timeout = (r_idle == 6'(TIMEOUT_TICKS));

    // Idle counter: runs only while editing, any button activity restarts it.
    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            r_idle <= 6'd0;
        end else if (r_state == S_RUN || r_state == S_COMMIT) begin
            r_idle <= 6'd0;
        end else if (w_mode_rise || w_edit_rise) begin
            r_idle <= 6'd0;
        end else if (!w_timeout) begin
            r_idle <= r_idle + 6'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_TICKS == 0);
`endif

    // Button history; loading 1 on reset masks buttons held through reset.
    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            r_mode_prev <= 1'b1;
            r_inc_prev  <= 1'b1;
            r_dec_prev  <= 1'b1;
        end else begin
            r_mode_prev <= btn_mode;
            r_inc_prev  <= btn_inc;
            r_dec_prev  <= btn_dec;
        end
    end

    // Edit FSM with shadow registers and registered status outputs.
    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            r_state      <= S_RUN;
            r_hours      <= 5'd0;
            r_minutes    <= 6'd0;
            r_seconds    <= 6'd0;
            r_load       <= 1'b0;
            r_set_active <= 1'b0;
            r_field_sel  <= 2'd0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_mode_rise) begin
                        r_hours      <= cur_hours;
                        r_minutes    <= cur_minutes;
                        r_seconds    <= cur_seconds;
                        r_state      <= S_SET_H;
                        r_set_active <= 1'b1;
                        r_field_sel  <= 2'd1;
                    end
                end
                S_SET_H: begin
                    if (w_mode_rise) begin
                        r_state     <= S_SET_M;
                        r_field_sel <= 2'd2;
                    end else if (w_edit_rise) begin
                        if (w_inc_only) r_hours <= w_hours_inc;
                        if (w_dec_only) r_hours <= w_hours_dec;
                    end else if (w_timeout) begin
                        r_state      <= S_RUN;
                        r_set_active <= 1'b0;
                        r_field_sel  <= 2'd0;
                    end
                end
                S_SET_M: begin
                    if (w_mode_rise) begin
                        r_state     <= S_SET_S;
                        r_field_sel <= 2'd3;
                    end else if (w_edit_rise) begin
                        if (w_inc_only) r_minutes <= w_minutes_inc;
                        if (w_dec_only) r_minutes <= w_minutes_dec;
                    end else if (w_timeout) begin
                        r_state      <= S_RUN;
                        r_set_active <= 1'b0;
                        r_field_sel  <= 2'd0;
                    end
                end
                S_SET_S: begin
                    if (w_mode_rise) begin
                        r_state      <= S_COMMIT;
                        r_load       <= 1'b1;
                        r_set_active <= 1'b0;
                        r_field_sel  <= 2'd0;
                    end else if (w_edit_rise) begin
                        if (w_inc_only) r_seconds <= w_seconds_inc;
                        if (w_dec_only) r_seconds <= w_seconds_dec;
                    end else if (w_timeout) begin
                        r_state      <= S_RUN;
                        r_set_active <= 1'b0;
                        r_field_sel  <= 2'd0;
                    end
                end
                S_COMMIT: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state      <= S_RUN;
                    r_set_active <= 1'b0;
                    r_field_sel  <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed vector table plus hand-written corner sequences.
// Build with SET_TIMEOUT_EN defined to exercise the idle timeout path.
module tb_clock_set_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic [4:0] init_hours;
    logic [5:0] init_minutes;
    logic [5:0] init_seconds;
    logic       load;
    logic       set_active;
    logic [1:0] field_sel;

    int n_cmp;
    int n_bad;

    clock_set_ctrl #(.TIMEOUT_TICKS(5)) dut (
        .Clk_1sec     (clk),
        .reset        (reset),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .cur_seconds  (cur_seconds),
        .init_hours   (init_hours),
        .init_minutes (init_minutes),
        .init_seconds (init_seconds),
        .load         (load),
        .set_active   (set_active),
        .field_sel    (field_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic       i;
        logic       d;
        logic [4:0] ch;
        logic [5:0] cm;
        logic [5:0] cs;
        logic       e_load;
        logic       e_act;
        logic [1:0] e_fs;
        logic [4:0] e_h;
        logic [5:0] e_m;
        logic [5:0] e_s;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic m, input logic i, input logic d,
                       input int ch, input int cm, input int cs,
                       input logic el, input logic ea, input int efs,
                       input int eh, input int em, input int es);
        vec_t v;
        v.m = m; v.i = i; v.d = d;
        v.ch = 5'(ch); v.cm = 6'(cm); v.cs = 6'(cs);
        v.e_load = el; v.e_act = ea; v.e_fs = 2'(efs);
        v.e_h = 5'(eh); v.e_m = 6'(em); v.e_s = 6'(es);
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] outs();
        return {load, set_active, field_sel,
                init_hours, init_minutes, init_seconds};
    endfunction

    task automatic check(input string name, input logic [20:0] got,
                         input logic [20:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ld=%0b act=%0b fs=%0d %0d:%0d:%0d want ld=%0b act=%0b fs=%0d %0d:%0d:%0d",
                     name, got[20], got[19], got[18:17], got[16:12],
                     got[11:6], got[5:0], exp[20], exp[19], exp[18:17],
                     exp[16:12], exp[11:6], exp[5:0]);
        end
    endtask

    task automatic check_bit(input string name, input logic got,
                             input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b", name, got, exp);
        end
    endtask

    initial begin
        int loads;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        btn_mode = 1'b1;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        cur_hours = 5'd2;
        cur_minutes = 6'd52;
        cur_seconds = 6'd0;

        // Reset with mode held: no transition after release.
        tick();
        tick();
        check("reset_held", outs(), 21'd0);
        reset = 1'b0;
        tick();
        check("held_after_rel1", outs(), 21'd0);
        tick();
        check("held_after_rel2", outs(), 21'd0);
        btn_mode = 1'b0;
        tick();
        check("held_released", outs(), 21'd0);

        // Full edit, no changes, cur 02:52:00.
        add(1,0,0, 2,52,0, 0,1,1, 2,52,0);
        add(0,0,0, 2,52,0, 0,1,1, 2,52,0);
        add(1,0,0, 2,52,0, 0,1,2, 2,52,0);
        add(0,0,0, 2,52,0, 0,1,2, 2,52,0);
        add(1,0,0, 2,52,0, 0,1,3, 2,52,0);
        add(0,0,0, 2,52,0, 0,1,3, 2,52,0);
        add(1,0,0, 2,52,0, 1,0,0, 2,52,0);
        add(0,0,0, 2,52,0, 0,0,0, 2,52,0);
        add(0,0,0, 2,52,0, 0,0,0, 2,52,0);
        // Wrap-around edit from 23:00:59 to 00:59:00.
        add(1,0,0, 23,0,59, 0,1,1, 23,0,59);
        add(0,0,0, 23,0,59, 0,1,1, 23,0,59);
        add(0,1,0, 23,0,59, 0,1,1, 0,0,59);
        add(0,0,0, 23,0,59, 0,1,1, 0,0,59);
        add(1,0,0, 23,0,59, 0,1,2, 0,0,59);
        add(0,0,0, 23,0,59, 0,1,2, 0,0,59);
        add(0,0,1, 23,0,59, 0,1,2, 0,59,59);
        add(0,0,0, 23,0,59, 0,1,2, 0,59,59);
        add(1,0,0, 23,0,59, 0,1,3, 0,59,59);
        add(0,0,0, 23,0,59, 0,1,3, 0,59,59);
        add(0,1,0, 23,0,59, 0,1,3, 0,59,0);
        add(0,0,0, 23,0,59, 0,1,3, 0,59,0);
        add(1,0,0, 23,0,59, 1,0,0, 0,59,0);
        add(0,0,0, 23,0,59, 0,0,0, 0,59,0);
        // inc/dec in RUN ignored.
        add(0,1,0, 23,0,59, 0,0,0, 0,59,0);
        add(0,0,1, 23,0,59, 0,0,0, 0,59,0);
        add(0,0,0, 23,0,59, 0,0,0, 0,59,0);
        // Simultaneous events from 10:20:30.
        add(1,0,0, 10,20,30, 0,1,1, 10,20,30);
        add(0,0,0, 10,20,30, 0,1,1, 10,20,30);
        add(1,1,0, 10,20,30, 0,1,2, 10,20,30);
        add(0,0,0, 10,20,30, 0,1,2, 10,20,30);
        add(0,1,1, 10,20,30, 0,1,2, 10,20,30);
        add(0,0,0, 10,20,30, 0,1,2, 10,20,30);
        add(0,0,1, 10,20,30, 0,1,2, 10,19,30);
        add(0,0,0, 10,20,30, 0,1,2, 10,19,30);
        add(0,1,0, 10,20,30, 0,1,2, 10,20,30);
        add(0,0,0, 10,20,30, 0,1,2, 10,20,30);
        add(1,0,1, 10,20,30, 0,1,3, 10,20,30);
        add(0,0,0, 10,20,30, 0,1,3, 10,20,30);
        add(0,0,1, 10,20,30, 0,1,3, 10,20,29);
        add(0,0,0, 10,20,30, 0,1,3, 10,20,29);
        add(1,0,0, 10,20,30, 1,0,0, 10,20,29);
        add(0,0,0, 10,20,30, 0,0,0, 10,20,29);
        // Hours 0 -> 23 -> 0, held buttons give one rise only.
        add(1,0,0, 0,0,0, 0,1,1, 0,0,0);
        add(0,0,0, 0,0,0, 0,1,1, 0,0,0);
        add(0,0,1, 0,0,0, 0,1,1, 23,0,0);
        add(0,0,1, 0,0,0, 0,1,1, 23,0,0);
        add(0,0,0, 0,0,0, 0,1,1, 23,0,0);
        add(0,1,0, 0,0,0, 0,1,1, 0,0,0);
        add(0,0,0, 0,0,0, 0,1,1, 0,0,0);
        add(1,0,0, 0,0,0, 0,1,2, 0,0,0);
        add(1,0,0, 0,0,0, 0,1,2, 0,0,0);
        add(0,0,0, 0,0,0, 0,1,2, 0,0,0);
        add(0,1,0, 0,0,0, 0,1,2, 0,1,0);
        add(0,0,0, 0,0,0, 0,1,2, 0,1,0);

        for (int k = 0; k < vecs.size(); k++) begin
            btn_mode = vecs[k].m;
            btn_inc = vecs[k].i;
            btn_dec = vecs[k].d;
            cur_hours = vecs[k].ch;
            cur_minutes = vecs[k].cm;
            cur_seconds = vecs[k].cs;
            tick();
            check($sformatf("vec%0d", k), outs(),
                  {vecs[k].e_load, vecs[k].e_act, vecs[k].e_fs,
                   vecs[k].e_h, vecs[k].e_m, vecs[k].e_s});
        end

        // Reset mid-edit (in SET_M, minutes edited to 1).
        reset = 1'b1;
        tick();
        check("reset_mid_edit", outs(), 21'd0);
        reset = 1'b0;
        loads = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (load === 1'b1) loads++;
        end
        check("after_mid_reset", outs(), 21'd0);
        n_cmp++;
        if (loads != 0) begin
            n_bad++;
            $display("FAIL no_load_after_reset: got %0d want 0", loads);
        end

        // Load strobe width over a full commit.
        cur_hours = 5'd7;
        cur_minutes = 6'd8;
        cur_seconds = 6'd9;
        loads = 0;
        for (int k = 0; k < 4; k++) begin
            btn_mode = 1'b1;
            tick();
            if (load === 1'b1) loads++;
            btn_mode = 1'b0;
            tick();
            if (load === 1'b1) loads++;
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (load === 1'b1) loads++;
        end
        n_cmp++;
        if (loads != 1) begin
            n_bad++;
            $display("FAIL load_width: got %0d cycles want 1", loads);
        end
        check("commit_789", outs(), {1'b0, 1'b0, 2'd0, 5'd7, 6'd8, 6'd9});

        // Idle behaviour in SET_H.
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        check_bit("idle_enter", set_active, 1'b1);
`ifdef SET_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            loads = 0;
            while (set_active === 1'b1 && waited < 20) begin
                tick();
                waited++;
                if (load === 1'b1) loads++;
            end
            n_cmp++;
            if (waited != 6) begin
                n_bad++;
                $display("FAIL timeout_ticks: got %0d want 6", waited);
            end
            check("timeout_run", outs(),
                  {1'b0, 1'b0, 2'd0, 5'd7, 6'd8, 6'd9});
            n_cmp++;
            if (loads != 0) begin
                n_bad++;
                $display("FAIL timeout_load: got %0d want 0", loads);
            end
        end
`else
        for (int k = 0; k < 100; k++) tick();
        check("no_timeout", outs(), {1'b0, 1'b1, 2'd1, 5'd7, 6'd8, 6'd9});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
